// File: rtl/icache_pkg.sv
// Shared types and width helpers for the instruction-cache refill unit.
// The width helpers take S (sets), B (line bytes) and ADDR_W so that every
// file derives offset/index/tag/word-count widths the same way.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    RECV   = 2'd2,
    COMMIT = 2'd3
  } refill_state_t;

  function automatic int off_w(input int b);
    return $clog2(b);
  endfunction

  function automatic int idx_w(input int s);
    return $clog2(s);
  endfunction

  function automatic int tag_w(input int addr_w, input int s, input int b);
    return addr_w - $clog2(s) - $clog2(b);
  endfunction

  function automatic int cnt_w(input int b);
    return $clog2(b / 4);
  endfunction

  localparam int DEF_S      = 64;
  localparam int DEF_B      = 64;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_OFF_W  = off_w(DEF_B);
  localparam int DEF_IDX_W  = idx_w(DEF_S);
  localparam int DEF_TAG_W  = tag_w(DEF_ADDR_W, DEF_S, DEF_B);
  localparam int DEF_CNT_W  = cnt_w(DEF_B);

endpackage

// File: rtl/icache_refill_unit_if.sv
// Memory-side handshake and cache fill bus of the refill unit.
// master: the refill unit; slave: memory plus the cache data/tag arrays.
interface icache_refill_unit_if
  import icache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int S      = 64,
  parameter int B      = 64
) ();

  localparam int IDX_W = idx_w(S);
  localparam int TAG_W = tag_w(ADDR_W, S, B);
  localparam int CNT_W = cnt_w(B);

  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [31:0]       mem_rdata_i;

  logic [IDX_W-1:0]  fill_set_o;
  logic [TAG_W-1:0]  fill_tag_o;
  logic              fill_we_o;
  logic [CNT_W-1:0]  fill_word_o;
  logic [31:0]       fill_data_o;
  logic              fill_commit_o;

  modport master (
    output mem_req_o, mem_addr_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output fill_set_o, fill_tag_o, fill_we_o, fill_word_o, fill_data_o, fill_commit_o
  );

  modport slave (
    input  mem_req_o, mem_addr_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  fill_set_o, fill_tag_o, fill_we_o, fill_word_o, fill_data_o, fill_commit_o
  );

endinterface

// File: rtl/icache_refill_unit.sv
// Instruction-cache line refill unit.
// On a permitted miss it latches the PC, requests the line from memory,
// streams each returned beat into the selected set as a registered word
// write, then pulses commit alongside the final write.
// Optional build macro ICACHE_CRITICAL_WORD_FIRST_EN: request the missed word
// first and place beats at (start_word + beat) mod WORDS.
module icache_refill_unit
  import icache_pkg::*;
#(
  parameter int S      = 64,
  parameter int B      = 64,
  parameter int ADDR_W = 32
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic [ADDR_W-1:0]    pc_fi_i,
  input  logic                 instr_hit_fi_i,
  input  logic                 ic_repl_permit_i,
  output logic                 refill_busy_o,
  icache_refill_unit_if.master bus
);

  localparam int WORDS = B / 4;
  localparam int OFF_W = off_w(B);
  localparam int IDX_W = idx_w(S);
  localparam int TAG_W = tag_w(ADDR_W, S, B);
  localparam int CNT_W = cnt_w(B);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(WORDS - 1);

  refill_state_t     state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  set_q;
  logic [TAG_W-1:0]  tag_q;
  logic [ADDR_W-1:0] addr_q;
  logic              req_q;
  logic              busy_q;
  logic              we_q;
  logic [CNT_W-1:0]  word_q;
  logic [31:0]       data_q;
  logic              commit_q;
  logic [CNT_W-1:0]  start_q;

  // Byte-offset bits of the PC only matter for critical-word-first ordering.
  logic unused_pc_offset;
  assign unused_pc_offset = ^pc_fi_i[OFF_W-1:0];

  // Request address and starting word for the latched miss.
  logic [ADDR_W-1:0] miss_addr;
  logic [CNT_W-1:0]  miss_start;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  assign miss_addr  = {pc_fi_i[ADDR_W-1:2], 2'b00};
  assign miss_start = pc_fi_i[OFF_W-1:2];
`else
  assign miss_addr  = {pc_fi_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign miss_start = '0;
`endif

  // Refill FSM: latch miss, hold request until grant, capture beats, commit.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      set_q    <= '0;
      tag_q    <= '0;
      addr_q   <= '0;
      req_q    <= 1'b0;
      busy_q   <= 1'b0;
      we_q     <= 1'b0;
      word_q   <= '0;
      data_q   <= '0;
      commit_q <= 1'b0;
      start_q  <= '0;
    end else begin
      we_q     <= 1'b0;
      commit_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!instr_hit_fi_i && ic_repl_permit_i) begin
            state_q <= REQ;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
            addr_q  <= miss_addr;
            set_q   <= pc_fi_i[OFF_W+IDX_W-1:OFF_W];
            tag_q   <= pc_fi_i[ADDR_W-1:OFF_W+IDX_W];
            start_q <= miss_start;
          end
        end
        REQ: begin
          // A beat coincident with the grant is not captured here.
          if (bus.mem_gnt_i) begin
            state_q <= RECV;
            req_q   <= 1'b0;
            cnt_q   <= '0;
          end
        end
        RECV: begin
          if (bus.mem_rvalid_i) begin
            we_q   <= 1'b1;
            data_q <= bus.mem_rdata_i;
            word_q <= start_q + cnt_q;
            cnt_q  <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BEAT) begin
              state_q  <= COMMIT;
              commit_q <= 1'b1;
            end
          end
        end
        COMMIT: begin
          // Final write and commit pulse are on the outputs this cycle.
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign refill_busy_o     = busy_q;
  assign bus.mem_req_o     = req_q;
  assign bus.mem_addr_o    = addr_q;
  assign bus.fill_set_o    = set_q;
  assign bus.fill_tag_o    = tag_q;
  assign bus.fill_we_o     = we_q;
  assign bus.fill_word_o   = word_q;
  assign bus.fill_data_o   = data_q;
  assign bus.fill_commit_o = commit_q;

endmodule

// File: tb/tb_icache_refill_unit.sv
// Randomized scoreboard bench for icache_refill_unit (S=64, B=64).
module tb_icache_refill_unit;
  import icache_pkg::*;

  localparam int S      = 64;
  localparam int B      = 64;
  localparam int ADDR_W = 32;
  localparam int WORDS  = B / 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [ADDR_W-1:0] pc;
  logic              hit;
  logic              permit;
  logic              busy;

  always #5 clk = ~clk;

  icache_refill_unit_if #(.ADDR_W(ADDR_W), .S(S), .B(B)) bus ();

  icache_refill_unit #(.S(S), .B(B), .ADDR_W(ADDR_W)) dut (
    .clk_i            (clk),
    .reset_n_i        (reset_n),
    .pc_fi_i          (pc),
    .instr_hit_fi_i   (hit),
    .ic_repl_permit_i (permit),
    .refill_busy_o    (busy),
    .bus              (bus)
  );

  typedef struct {
    int          word;
    logic [31:0] data;
    bit          commit;
  } wr_t;

  wr_t  exp_q[$];
  wr_t  mon_e;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   commits_seen = 0;
  longint exp_set = 0;
  longint exp_tag = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: address split and burst ordering from plain arithmetic.
  function automatic longint m_addr(input longint a);
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    return a - (a % 4);
`else
    return a - (a % B);
`endif
  endfunction

  function automatic int m_start(input longint a);
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    return int'((a % B) / 4);
`else
    return 0;
`endif
  endfunction

  // Monitor: every fill write must match the head of the expected queue.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (bus.fill_we_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 64'(bus.fill_word_o), 64'hFFFF);
        end else begin
          mon_e = exp_q.pop_front();
          chk("fill_word", 64'(bus.fill_word_o), 64'(mon_e.word));
          chk("fill_data", 64'(bus.fill_data_o), 64'(mon_e.data));
          chk("fill_commit", 64'(bus.fill_commit_o), 64'(mon_e.commit));
          chk("fill_set", 64'(bus.fill_set_o), 64'(exp_set));
          chk("fill_tag", 64'(bus.fill_tag_o), 64'(exp_tag));
        end
      end else if (bus.fill_commit_o !== 1'b0) begin
        chk("commit_without_write", 64'(bus.fill_commit_o), 64'h0);
      end
      if (bus.fill_commit_o === 1'b1) commits_seen++;
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_req"},    64'(bus.mem_req_o), 0);
    chk({tag, "_addr"},   64'(bus.mem_addr_o), 0);
    chk({tag, "_busy"},   64'(busy), 0);
    chk({tag, "_we"},     64'(bus.fill_we_o), 0);
    chk({tag, "_commit"}, 64'(bus.fill_commit_o), 0);
    chk({tag, "_set"},    64'(bus.fill_set_o), 0);
    chk({tag, "_tag"},    64'(bus.fill_tag_o), 0);
    chk({tag, "_word"},   64'(bus.fill_word_o), 0);
    chk({tag, "_data"},   64'(bus.fill_data_o), 0);
  endtask

  // One refill: miss, optional grant delay, beats with optional gaps.
  // rst_at >= 0 pulls reset low in place of that beat.
  task automatic refill(input logic [ADDR_W-1:0] a, input int gdly, input bit gaps,
                        input bit drop_permit, input bit fixed_data, input int rst_at);
    int base;
    int n;
    logic [31:0] d;
    base = commits_seen;
    @(posedge clk); #1;
    pc = a; hit = 1'b0; permit = 1'b1;
    exp_set = (longint'(a) / B) % S;
    exp_tag = longint'(a) / (B * S);
    @(posedge clk); #1;
    hit = 1'b1; pc = $urandom;
    n = 0;
    while (bus.mem_req_o !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("req_asserted", 64'(bus.mem_req_o), 1);
    chk("busy_in_req", 64'(busy), 1);
    chk("mem_addr", 64'(bus.mem_addr_o), 64'(m_addr(longint'(a))));
    repeat (gdly) begin
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = $urandom;
      @(posedge clk); #1;
      bus.mem_rvalid_i = 1'b0;
      chk("req_held", 64'(bus.mem_req_o), 1);
      chk("addr_held", 64'(bus.mem_addr_o), 64'(m_addr(longint'(a))));
    end
    bus.mem_gnt_i = 1'b1;
    @(posedge clk); #1;
    bus.mem_gnt_i = 1'b0;
    chk("req_dropped_after_gnt", 64'(bus.mem_req_o), 0);
    if (drop_permit) permit = 1'b0;
    for (int k = 0; k < WORDS; k++) begin
      if (k == rst_at) begin
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        exp_q.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("no_commit_after_reset", 64'(commits_seen), 64'(base));
        return;
      end
      if (gaps) begin
        bus.mem_rvalid_i = 1'b0;
        @(posedge clk); #1;
      end
      d = fixed_data ? 32'hA0 + 32'(k) : $urandom;
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = d;
      exp_q.push_back('{word: (m_start(longint'(a)) + k) % WORDS, data: d, commit: (k == WORDS - 1)});
      @(posedge clk); #1;
      bus.mem_rvalid_i = 1'b0;
      chk("busy_during_recv", 64'(busy), 1);
    end
    n = 0;
    while (commits_seen == base && n < 10) begin
      @(posedge clk); #1; n++;
    end
    chk("commit_count", 64'(commits_seen - base), 1);
    chk("sb_drained", 64'(exp_q.size()), 0);
    chk("busy_cleared", 64'(busy), 0);
    permit = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    pc = '0; hit = 1'b1; permit = 1'b0;
    bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset_n = 1'b1;

    // Directed line fill with immediate back-to-back beats.
    refill(32'h0000_1234, 2, 1'b0, 1'b0, 1'b1, -1);

    // Miss without permission, with stray beats: nothing happens.
    @(posedge clk); #1;
    pc = 32'h0000_5678; hit = 1'b0; permit = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.mem_rvalid_i = i[0];
      bus.mem_rdata_i  = $urandom;
      @(posedge clk); #1;
      chk("noperm_req", 64'(bus.mem_req_o), 0);
      chk("noperm_busy", 64'(busy), 0);
    end
    bus.mem_rvalid_i = 1'b0;
    hit = 1'b1; permit = 1'b1;

    // Beats every other cycle.
    refill($urandom, 1, 1'b1, 1'b0, 1'b0, -1);

    // Permit dropped mid-transfer.
    refill($urandom, 0, 1'b0, 1'b1, 1'b0, -1);

    // Reset at beat 7, then a fresh refill of the same line.
    refill(32'h0000_1234, 1, 1'b0, 1'b0, 1'b1, 7);
    refill(32'h0000_1234, 0, 1'b0, 1'b0, 1'b1, -1);

    // Randomized refills.
    for (int r = 0; r < 8; r++) begin
      refill($urandom, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
             bit'($urandom_range(0, 1)), 1'b0, -1);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("final_idle_busy", 64'(busy), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
